// File: rtl/perf_counter_bank.sv
// Bank of N_EVT event counters with wrap/saturate overflow, sticky overflow flags,
// snapshot registers and a registered readout mux with optional auto-scan.
module perf_counter_bank #(
    parameter int N_EVT    = 5,
    parameter int CNT_W    = 32,
    parameter int SCAN_DIV = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_EVT-1:0] evt,
    input  logic             clr,
    input  logic             freeze,
    input  logic             sat_mode,
    input  logic             snap,
    input  logic             use_snap,
    input  logic             auto_scan,
    input  logic [3:0]       sel,
    output logic [CNT_W-1:0] value,
    output logic [3:0]       cur_ch,
    output logic [N_EVT-1:0] ovf
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       CH_LAST  = 4'(N_EVT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] r_cnt  [N_EVT];
    logic [CNT_W-1:0] r_snap [N_EVT];
    logic [N_EVT-1:0] r_ovf;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_scan_ch;
    logic [CNT_W-1:0] r_value;
    logic [3:0]       r_cur_ch;

    logic [3:0]       w_ch;
    logic [CNT_W-1:0] w_rd;

    // Loop compare instead of direct indexing so out-of-range selects read zero.
    always_comb begin
        w_ch = auto_scan ? r_scan_ch : sel;
        w_rd = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (w_ch == 4'(i)) begin
                w_rd = use_snap ? r_snap[i] : r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < N_EVT; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < N_EVT; i++) begin
                if (snap) begin
                    r_snap[i] <= r_cnt[i];
                end
                if (!freeze && evt[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                        if (!sat_mode) begin
                            r_cnt[i] <= '0;
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Divider and scan channel only advance while auto_scan is high.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_div     <= '0;
            r_scan_ch <= '0;
        end else if (auto_scan) begin
            if (r_div == DIV_LAST) begin
                r_div     <= '0;
                r_scan_ch <= (r_scan_ch == CH_LAST) ? 4'd0 : r_scan_ch + 4'd1;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_value  <= '0;
            r_cur_ch <= '0;
        end else begin
            r_value  <= w_rd;
            r_cur_ch <= w_ch;
        end
    end

    assign value  = r_value;
    assign cur_ch = r_cur_ch;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized and directed bench for perf_counter_bank against a cycle-level
// reference model built from the counting rules (modular arithmetic, scan by cycle count).
module tb_perf_counter_bank;

    localparam int NE   = 5;
    localparam int CW   = 4;
    localparam int SD   = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NE-1:0] evt;
    logic          clr, freeze, sat_mode, snap, use_snap, auto_scan;
    logic [3:0]    sel;
    logic [CW-1:0] value;
    logic [3:0]    cur_ch;
    logic [NE-1:0] ovf;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state: what the outputs and counters are after the last edge
    int            m_cnt [NE];
    int            m_snp [NE];
    logic [NE-1:0] m_ovf;
    int            m_val, m_ch;
    int            m_ac;   // cycles spent with auto_scan high since reset/clr

    perf_counter_bank #(.N_EVT(NE), .CNT_W(CW), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .evt(evt), .clr(clr), .freeze(freeze),
        .sat_mode(sat_mode), .snap(snap), .use_snap(use_snap),
        .auto_scan(auto_scan), .sel(sel), .value(value), .cur_ch(cur_ch), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int c;
        if (!rst_n || clr) begin
            for (int i = 0; i < NE; i++) begin
                m_cnt[i] = 0;
                m_snp[i] = 0;
            end
            m_ovf = '0;
            m_val = 0;
            m_ch  = 0;
            m_ac  = 0;
        end else begin
            c     = auto_scan ? (m_ac / SD) % NE : int'(sel);
            m_ch  = c;
            m_val = (c < NE) ? (use_snap ? m_snp[c] : m_cnt[c]) : 0;
            if (auto_scan) m_ac++;
            if (snap) begin
                for (int i = 0; i < NE; i++) m_snp[i] = m_cnt[i];
            end
            if (!freeze) begin
                for (int i = 0; i < NE; i++) begin
                    if (evt[i]) begin
                        if (m_cnt[i] + 1 > MAXV) begin
                            m_ovf[i] = 1'b1;
                            m_cnt[i] = sat_mode ? MAXV : 0;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                end
            end
        end
    endtask

    // Apply current inputs across one rising edge, then compare at the falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        check("value",  32'(value),  32'(m_val));
        check("cur_ch", 32'(cur_ch), 32'(m_ch));
        check("ovf",    32'(ovf),    32'(m_ovf));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0; evt = '1; clr = 1'b0; freeze = 1'b0; sat_mode = 1'b0;
        snap = 1'b0; use_snap = 1'b0; auto_scan = 1'b0; sel = 4'd0;
        for (int i = 0; i < NE; i++) begin m_cnt[i] = 0; m_snp[i] = 0; end
        m_ovf = '0; m_val = 0; m_ch = 0; m_ac = 0;

        // reset with all events high
        ticks(2);
        check("rst_value", 32'(value), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_cur_ch", 32'(cur_ch), 0);

        // seven increments on channel 2
        rst_n = 1'b1; sel = 4'd2; evt = 5'b00100;
        ticks(7);
        evt = '0;
        ticks(2);
        check("inc7_value", 32'(value), 7);
        for (int c = 0; c < NE; c++) begin
            if (c != 2) begin
                sel = 4'(c);
                tick();
                check("other_ch_zero", 32'(value), 0);
            end
        end

        // wrap mode: 17 pulses -> 1
        clr = 1'b1; tick(); clr = 1'b0;
        sel = 4'd0; sat_mode = 1'b0; evt = 5'b00001;
        ticks(17);
        evt = '0; tick();
        check("wrap_value", 32'(value), 1);
        check("wrap_ovf0", 32'(ovf[0]), 1);

        // saturate mode: 17 pulses -> 15
        clr = 1'b1; tick(); clr = 1'b0;
        sat_mode = 1'b1; evt = 5'b00001;
        ticks(17);
        evt = '0; tick();
        check("sat_value", 32'(value), 15);
        check("sat_ovf0", 32'(ovf[0]), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_value", 32'(value), 0);
        check("clr_ovf", 32'(ovf), 0);
        sat_mode = 1'b0;

        // priority: clr over evt, freeze over evt, snap takes pre-edge value
        clr = 1'b1; evt = 5'b00010; tick();
        clr = 1'b0; evt = '0; sel = 4'd1; tick();
        check("clr_beats_evt", 32'(value), 0);
        freeze = 1'b1; evt = 5'b00010; ticks(5);
        freeze = 1'b0; evt = '0; tick();
        check("freeze_hold", 32'(value), 0);
        evt = 5'b01000; ticks(9);
        snap = 1'b1; tick();
        snap = 1'b0; evt = '0; use_snap = 1'b1; sel = 4'd3; tick();
        check("snap_value", 32'(value), 9);
        use_snap = 1'b0; tick();
        check("live_after_snap", 32'(value), 10);

        // auto-scan stepping and wrap
        clr = 1'b1; auto_scan = 1'b1; tick(); clr = 1'b0;
        ticks(5);
        check("scan_first_step", 32'(cur_ch), 1);
        ticks(19);
        check("scan_wrap", 32'(cur_ch), 0);
        auto_scan = 1'b0; sel = 4'd7; evt = 5'b10000;
        ticks(10);
        check("oor_value", 32'(value), 0);
        check("oor_cur_ch", 32'(cur_ch), 7);
        evt = '0; sel = 4'd4; tick();
        check("sel4_value", 32'(value), 10);
        auto_scan = 1'b1; ticks(12);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            evt       = NE'($urandom);
            rst_n     = ($urandom_range(0, 199) != 0);
            clr       = ($urandom_range(0, 59) == 0);
            freeze    = ($urandom_range(0, 4) == 0);
            snap      = ($urandom_range(0, 7) == 0);
            use_snap  = 1'($urandom_range(0, 1));
            sel       = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) sat_mode  = ~sat_mode;
            if ($urandom_range(0, 63) == 0) auto_scan = ~auto_scan;
            tick();
        end

        // reset in the middle of activity
        rst_n = 1'b1; clr = 1'b0; freeze = 1'b0; auto_scan = 1'b1; evt = 5'b11011;
        ticks(6);
        snap = 1'b1; tick(); snap = 1'b0;
        ticks(3);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; evt = '0; auto_scan = 1'b0;
        check("midrst_value", 32'(value), 0);
        check("midrst_cur_ch", 32'(cur_ch), 0);
        check("midrst_ovf", 32'(ovf), 0);
        for (int c = 0; c < NE; c++) begin
            sel = 4'(c); use_snap = 1'b0; tick();
            check("midrst_live", 32'(value), 0);
            use_snap = 1'b1; tick();
            check("midrst_snap", 32'(value), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
